dldo_pass_ctrl: RTL and testbench
=================================

# dldo_pass_ctrl

Parametrised controller for the digital LDO. It converts the latched comparator decision into a saturating N-bit thermometer code of pass-device enables. Adaptive-step tracking runs coarse, then fine, then locked. A registered test override drives the gates directly. It sits between the comparator/RS-latch/inverter chain (`ldotop_cmp`) and the pass-transistor array gates (`ldotop_gate`).

## Interface
- N_PASS, 32: number of pass devices; CW = $clog2(N_PASS+1)
- STEP_COARSE, 4: code step in COARSE state; legal 1..N_PASS
- INIT_CODE, 16: code loaded at reset; legal 0..N_PASS
- LOCK_CNT, 4: consecutive reversals in FINE needed to enter LOCKED; ≥2
- UNLOCK_RUN, 3: consecutive same-polarity samples in LOCKED needed to exit; ≥2
- ldotop_clk  in  1  sole clock, rising edge
- ldotop_rst  in  1  reset, synchronous, active-high
- ldotop_cmp  in  1  comparator decision; 1 = vout below ref (increase code), 0 = decrease
- ldotop_cmp_valid  in  1  `ldotop_cmp` is sampled only on cycles where this is high
- ldotop_test  in  1  test override enable
- ldotop_test_in  in  N_PASS  gate pattern applied in test mode
- ldotop_gate  out  N_PASS  registered pass-device enables; 1 = device on
- ldotop_code  out  CW  current tracking code (cnt)
- ldotop_state  out  2  0 = COARSE, 1 = FINE, 2 = LOCKED
- ldotop_lock  out  1  high while in LOCKED
- ldotop_sat  out  1  high while cnt == 0 or cnt == N_PASS

## Operation
- **Registers**
  - cnt (CW bits)
  - state
  - prev_cmp, plus prev_ok (prev_cmp holds a real sample)
  - rev_cnt, run_cnt
  - hold_code
  - dith (phase bit)
- **Reset values**
  - cnt = INIT_CODE, state = COARSE
  - prev_ok = 0, rev_cnt = 0, run_cnt = 0, dith = 0
  - ldotop_gate = therm(INIT_CODE), ldotop_lock = 0
  - ldotop_sat = (INIT_CODE == 0 || INIT_CODE == N_PASS)
- **Thermometer code:** therm(c)[i] = (i < c).
- **Reversal:** a valid sample is a reversal when prev_ok and cmp != prev_cmp. Every valid sample sets prev_ok = 1 and prev_cmp = cmp.
- **COARSE**
  - Non-reversal: cnt ± STEP_COARSE.
  - Reversal: cnt ± 1, then go to FINE with rev_cnt = 1.
- **FINE**
  - Every valid sample: cnt ± 1.
  - rev_cnt increments on a reversal and clears to 0 on a non-reversal.
  - When a reversal makes rev_cnt reach LOCK_CNT: go to LOCKED, set hold_code = cnt, leave cnt unchanged on that sample, clear run_cnt.
- **LOCKED**
  - cnt is held at hold_code.
  - run_cnt increments on a non-reversal and clears on a reversal.
  - When run_cnt reaches UNLOCK_RUN: go to COARSE, apply ±STEP_COARSE to cnt on that sample, clear rev_cnt.
- **Arithmetic:** computed at CW+1 bits. Saturate to [0, N_PASS], never wrap. A step at a rail leaves cnt at the rail and the state machine still advances.
- **Gate source**
  - Normal mode: ldotop_gate = therm(applied code).
  - Applied code = cnt, except in LOCKED with dither (see Configuration).
- **Test mode** (ldotop_test = 1)
  - ldotop_gate <= ldotop_test_in every cycle.
  - cnt, state, counters, prev_cmp and dith are frozen; cmp_valid is ignored.
  - On deassertion, the gates return to therm(applied code) on the next edge and tracking resumes from the frozen state.
- **Reset priority:** ldotop_rst overrides test and valid, including in mid-lock and mid-test.

## Timing
- A valid sample at edge t updates cnt, state, ldotop_gate, ldotop_code, ldotop_lock and ldotop_sat at that same edge. The new value is visible in cycle t+1, so latency is 1 cycle.
- With no valid sample, all outputs hold.
- Consecutive valid samples on back-to-back cycles are supported at full rate.
- Test override latency is 1 cycle in both directions.
- Reset asserted at edge t: all reset values are visible from cycle t+1.

## Configuration
- Macro: **DLDO_DITHER_EN**.
- **Defined:** in LOCKED, each valid sample toggles dith.
  - Applied code = hold_code + dith, saturated at N_PASS.
  - dith clears on entry to and exit from LOCKED.
  - ldotop_code still reports hold_code.
- **Undefined:** in LOCKED, applied code = hold_code constant. The dith register is not built.

## Test plan
- **Reset and slew up:** reset with defaults, then 5 valid samples cmp = 1.
  - Expected: code 16 → 20 → 24 → 28 → 32 → 32.
  - gate = 32'hFFFF_FFFF; sat = 1 from the 4th sample; state stays 0.
- **Coarse-to-fine:** from code 16, valid cmp sequence 1, 0.
  - Expected: 20, then 19 with state = 1.
- **Lock entry:** alternate cmp 1, 0, 1, 0, … after reaching FINE.
  - Expected: lock = 1 when rev_cnt hits 4.
  - hold_code equals the code before the locking sample; code frozen thereafter.
- **Unlock on load step:** in LOCKED, apply 3 consecutive cmp = 1.
  - Expected: state = 0 and code = hold_code + 4 on the 3rd sample; lock = 0.
- **Test override:** ldotop_test = 1 with test_in = 32'hA5A5_0F0F while toggling cmp_valid.
  - Expected: gate = A5A5_0F0F after 1 cycle; code unchanged.
  - Release ldotop_test: gate returns to therm(code) 1 cycle later.
- **Dither (DLDO_DITHER_EN defined):** in LOCKED with hold_code = 10 and alternating valid samples.
  - Expected: gate alternates therm(11), therm(10), …; code stays 10.
  - With hold_code = 32: gate stays all-ones.

Source files
------------

// File: rtl/dldo_pass_ctrl.sv
// Digital-LDO pass-device controller: adaptive-step (coarse/fine/locked) tracking of a
// saturating thermometer code, with a registered test override. Optional macro: DLDO_DITHER_EN.
module dldo_pass_ctrl #(
    parameter  int N_PASS      = 32,
    parameter  int STEP_COARSE = 4,
    parameter  int INIT_CODE   = 16,
    parameter  int LOCK_CNT    = 4,
    parameter  int UNLOCK_RUN  = 3,
    localparam int CW          = $clog2(N_PASS + 1)
) (
    input  logic              ldotop_clk,
    input  logic              ldotop_rst,
    input  logic              ldotop_cmp,
    input  logic              ldotop_cmp_valid,
    input  logic              ldotop_test,
    input  logic [N_PASS-1:0] ldotop_test_in,
    output logic [N_PASS-1:0] ldotop_gate,
    output logic [CW-1:0]     ldotop_code,
    output logic [1:0]        ldotop_state,
    output logic              ldotop_lock,
    output logic              ldotop_sat
);

    localparam int RW = $clog2(LOCK_CNT + 1);
    localparam int UW = $clog2(UNLOCK_RUN + 1);
    localparam logic [CW:0]   NP_W     = (CW+1)'(N_PASS);
    localparam logic [CW:0]   STEP_W   = (CW+1)'(STEP_COARSE);
    localparam logic [CW:0]   ONE_W    = {{CW{1'b0}}, 1'b1};
    localparam logic [CW-1:0] FULL_W   = CW'(N_PASS);
    localparam logic [CW-1:0] INIT_W   = CW'(INIT_CODE);
    localparam logic [RW-1:0] LOCK_W   = RW'(LOCK_CNT);
    localparam logic [RW-1:0] REV_ONE  = {{(RW-1){1'b0}}, 1'b1};
    localparam logic [UW-1:0] RUN_W    = UW'(UNLOCK_RUN);
    localparam logic [UW-1:0] RUN_ONE  = {{(UW-1){1'b0}}, 1'b1};
    localparam logic          SAT_INIT = (INIT_CODE == 0) || (INIT_CODE == N_PASS);

    typedef enum logic [1:0] {
        ST_COARSE = 2'd0,
        ST_FINE   = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    function automatic logic [N_PASS-1:0] therm_f(input logic [CW-1:0] c);
        logic [N_PASS-1:0] t;
        for (int i = 0; i < N_PASS; i++) begin
            t[i] = (i < int'(c));
        end
        return t;
    endfunction

    // Move c by step toward the comparator's request, clamped to [0, N_PASS].
    function automatic logic [CW-1:0] step_f(input logic [CW-1:0] c, input logic up,
                                             input logic [CW:0] step);
        logic [CW:0]   ext;
        logic [CW:0]   sum;
        logic [CW:0]   dif;
        logic [CW-1:0] r;
        ext = {1'b0, c};
        sum = ext + step;
        dif = ext - step;
        if (up) begin
            if (sum > NP_W) r = FULL_W;
            else            r = sum[CW-1:0];
        end else begin
            if (ext < step) r = {CW{1'b0}};
            else            r = dif[CW-1:0];
        end
        return r;
    endfunction

`ifdef DLDO_DITHER_EN
    function automatic logic [CW-1:0] dith_code_f(input logic [CW-1:0] h, input logic d);
        logic [CW:0]   s;
        logic [CW-1:0] r;
        s = {1'b0, h} + {{CW{1'b0}}, d};
        if (s > NP_W) r = FULL_W;
        else          r = s[CW-1:0];
        return r;
    endfunction
`endif

    state_t            state_r, state_s;
    logic [CW-1:0]     cnt_r, cnt_s;
    logic [CW-1:0]     hold_code_r, hold_code_s;
    logic              prev_cmp_r, prev_cmp_s;
    logic              prev_ok_r, prev_ok_s;
    logic [RW-1:0]     rev_cnt_r, rev_cnt_s;
    logic [UW-1:0]     run_cnt_r, run_cnt_s;
    logic [N_PASS-1:0] gate_r, gate_s;
    logic              lock_r, lock_s;
    logic              sat_r, sat_s;
    logic [CW-1:0]     applied_s;
    logic              valid_s;
    logic              rev_s;
`ifdef DLDO_DITHER_EN
    logic              dith_r, dith_s;
`endif

    assign valid_s = ldotop_cmp_valid & ~ldotop_test;
    assign rev_s   = prev_ok_r & (ldotop_cmp ^ prev_cmp_r);

    // Tracking state machine: next code, state and counters for one comparator sample.
    always_comb begin
        state_s     = state_r;
        cnt_s       = cnt_r;
        hold_code_s = hold_code_r;
        prev_cmp_s  = prev_cmp_r;
        prev_ok_s   = prev_ok_r;
        rev_cnt_s   = rev_cnt_r;
        run_cnt_s   = run_cnt_r;
`ifdef DLDO_DITHER_EN
        dith_s      = dith_r;
`endif
        if (valid_s) begin
            prev_ok_s  = 1'b1;
            prev_cmp_s = ldotop_cmp;
            case (state_r)
                ST_COARSE: begin
                    if (rev_s) begin
                        cnt_s     = step_f(cnt_r, ldotop_cmp, ONE_W);
                        state_s   = ST_FINE;
                        rev_cnt_s = REV_ONE;
                    end else begin
                        cnt_s = step_f(cnt_r, ldotop_cmp, STEP_W);
                    end
                end
                ST_FINE: begin
                    if (rev_s && ((rev_cnt_r + REV_ONE) == LOCK_W)) begin
                        // The locking sample freezes the code it arrived at.
                        state_s     = ST_LOCKED;
                        hold_code_s = cnt_r;
                        run_cnt_s   = {UW{1'b0}};
`ifdef DLDO_DITHER_EN
                        dith_s      = 1'b0;
`endif
                    end else if (rev_s) begin
                        cnt_s     = step_f(cnt_r, ldotop_cmp, ONE_W);
                        rev_cnt_s = rev_cnt_r + REV_ONE;
                    end else begin
                        cnt_s     = step_f(cnt_r, ldotop_cmp, ONE_W);
                        rev_cnt_s = {RW{1'b0}};
                    end
                end
                ST_LOCKED: begin
                    cnt_s = hold_code_r;
                    if (rev_s) begin
                        run_cnt_s = {UW{1'b0}};
`ifdef DLDO_DITHER_EN
                        dith_s    = ~dith_r;
`endif
                    end else if ((run_cnt_r + RUN_ONE) == RUN_W) begin
                        // A sustained one-sided error means the load moved: re-acquire coarsely.
                        state_s   = ST_COARSE;
                        cnt_s     = step_f(hold_code_r, ldotop_cmp, STEP_W);
                        rev_cnt_s = {RW{1'b0}};
                        run_cnt_s = {UW{1'b0}};
`ifdef DLDO_DITHER_EN
                        dith_s    = 1'b0;
`endif
                    end else begin
                        run_cnt_s = run_cnt_r + RUN_ONE;
`ifdef DLDO_DITHER_EN
                        dith_s    = ~dith_r;
`endif
                    end
                end
                default: begin
                    state_s = ST_COARSE;
                end
            endcase
        end else begin
            prev_ok_s = prev_ok_r;
        end
    end

    // Output decode: applied code to gates (or test pattern), lock and rail flags.
    always_comb begin
        applied_s = cnt_s;
`ifdef DLDO_DITHER_EN
        if (state_s == ST_LOCKED) applied_s = dith_code_f(hold_code_s, dith_s);
        else                      applied_s = cnt_s;
`endif
        if (ldotop_test) gate_s = ldotop_test_in;
        else             gate_s = therm_f(applied_s);
        lock_s = (state_s == ST_LOCKED);
        sat_s  = (cnt_s == {CW{1'b0}}) || (cnt_s == FULL_W);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge ldotop_clk) begin
        if (ldotop_rst) begin
            state_r     <= ST_COARSE;
            cnt_r       <= INIT_W;
            hold_code_r <= INIT_W;
            prev_cmp_r  <= 1'b0;
            prev_ok_r   <= 1'b0;
            rev_cnt_r   <= {RW{1'b0}};
            run_cnt_r   <= {UW{1'b0}};
            gate_r      <= therm_f(INIT_W);
            lock_r      <= 1'b0;
            sat_r       <= SAT_INIT;
        end else begin
            state_r     <= state_s;
            cnt_r       <= cnt_s;
            hold_code_r <= hold_code_s;
            prev_cmp_r  <= prev_cmp_s;
            prev_ok_r   <= prev_ok_s;
            rev_cnt_r   <= rev_cnt_s;
            run_cnt_r   <= run_cnt_s;
            gate_r      <= gate_s;
            lock_r      <= lock_s;
            sat_r       <= sat_s;
        end
    end

`ifdef DLDO_DITHER_EN
    // Dither phase register.
    always_ff @(posedge ldotop_clk) begin
        if (ldotop_rst) dith_r <= 1'b0;
        else            dith_r <= dith_s;
    end
`endif

    assign ldotop_gate  = gate_r;
    assign ldotop_code  = cnt_r;
    assign ldotop_state = state_r;
    assign ldotop_lock  = lock_r;
    assign ldotop_sat   = sat_r;

endmodule

// File: tb/tb_dldo_pass_ctrl.sv
// Scoreboard bench for dldo_pass_ctrl: a behavioural model predicts every cycle's outputs,
// a monitor pops and compares them one edge later.
module tb_dldo_pass_ctrl;

    localparam int N_PASS      = 32;
    localparam int STEP_COARSE = 4;
    localparam int INIT_CODE   = 16;
    localparam int LOCK_CNT    = 4;
    localparam int UNLOCK_RUN  = 3;
    localparam int CW          = $clog2(N_PASS + 1);

    logic              ldotop_clk = 1'b0;
    logic              ldotop_rst = 1'b0;
    logic              ldotop_cmp = 1'b0;
    logic              ldotop_cmp_valid = 1'b0;
    logic              ldotop_test = 1'b0;
    logic [N_PASS-1:0] ldotop_test_in = '0;
    logic [N_PASS-1:0] ldotop_gate;
    logic [CW-1:0]     ldotop_code;
    logic [1:0]        ldotop_state;
    logic              ldotop_lock;
    logic              ldotop_sat;

    dldo_pass_ctrl #(
        .N_PASS(N_PASS), .STEP_COARSE(STEP_COARSE), .INIT_CODE(INIT_CODE),
        .LOCK_CNT(LOCK_CNT), .UNLOCK_RUN(UNLOCK_RUN)
    ) dut (
        .ldotop_clk(ldotop_clk), .ldotop_rst(ldotop_rst), .ldotop_cmp(ldotop_cmp),
        .ldotop_cmp_valid(ldotop_cmp_valid), .ldotop_test(ldotop_test),
        .ldotop_test_in(ldotop_test_in), .ldotop_gate(ldotop_gate), .ldotop_code(ldotop_code),
        .ldotop_state(ldotop_state), .ldotop_lock(ldotop_lock), .ldotop_sat(ldotop_sat)
    );

    always #5 ldotop_clk = ~ldotop_clk;

    typedef struct {
        logic [N_PASS-1:0] gate;
        int                code;
        int                state;
        bit                lock;
        bit                sat;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    // Reference model: mode 0 = coarse, 1 = fine, 2 = locked.
    int m_code, m_mode, m_rev, m_run, m_hold, m_dith;
    bit m_prev, m_prev_ok;

    function automatic int clamp(int v);
        if (v < 0) return 0;
        if (v > N_PASS) return N_PASS;
        return v;
    endfunction

    function automatic logic [N_PASS-1:0] therm_m(int c);
        logic [63:0] m;
        m = (64'd1 << c) - 64'd1;
        return m[N_PASS-1:0];
    endfunction

    task automatic model_step(bit rst, bit test, logic [N_PASS-1:0] tin, bit valid, bit cmp);
        exp_t e;
        bit   rev;
        int   dir;
        int   applied;
        if (rst) begin
            m_code = INIT_CODE; m_mode = 0; m_prev = 0; m_prev_ok = 0;
            m_rev = 0; m_run = 0; m_hold = INIT_CODE; m_dith = 0;
        end else if (!test && valid) begin
            rev = m_prev_ok && (cmp != m_prev);
            dir = cmp ? 1 : -1;
            m_prev_ok = 1; m_prev = cmp;
            if (m_mode == 0) begin
                if (rev) begin
                    m_code = clamp(m_code + dir); m_mode = 1; m_rev = 1;
                end else begin
                    m_code = clamp(m_code + dir * STEP_COARSE);
                end
            end else if (m_mode == 1) begin
                if (rev && (m_rev + 1 == LOCK_CNT)) begin
                    m_mode = 2; m_hold = m_code; m_run = 0; m_dith = 0;
                end else begin
                    m_code = clamp(m_code + dir);
                    m_rev  = rev ? m_rev + 1 : 0;
                end
            end else begin
                m_run = rev ? 0 : m_run + 1;
                if (m_run == UNLOCK_RUN) begin
                    m_mode = 0; m_code = clamp(m_hold + dir * STEP_COARSE);
                    m_rev = 0; m_run = 0; m_dith = 0;
                end else begin
                    m_dith = 1 - m_dith;
                end
            end
        end
        applied = m_code;
`ifdef DLDO_DITHER_EN
        if (m_mode == 2) applied = clamp(m_hold + m_dith);
`endif
        e.gate  = (!rst && test) ? tin : therm_m(applied);
        e.code  = m_code;
        e.state = m_mode;
        e.lock  = (m_mode == 2);
        e.sat   = (m_code == 0) || (m_code == N_PASS);
        exp_q.push_back(e);
    endtask

    task automatic drive(bit rst, bit test, logic [N_PASS-1:0] tin, bit valid, bit cmp);
        @(negedge ldotop_clk);
        ldotop_rst = rst; ldotop_test = test; ldotop_test_in = tin;
        ldotop_cmp_valid = valid; ldotop_cmp = cmp;
        model_step(rst, test, tin, valid, cmp);
    endtask

    task automatic chk(string name, logic [63:0] got, logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s cycle %0d got %h want %h", name, cyc, got, want);
        end
    endtask

    // Monitor: the DUT updates every edge, so one expectation is retired per edge.
    always @(posedge ldotop_clk) begin
        exp_t e;
        #1;
        cyc++;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("gate",  64'(ldotop_gate),  64'(e.gate));
            chk("code",  64'(ldotop_code),  64'(e.code));
            chk("state", 64'(ldotop_state), 64'(e.state));
            chk("lock",  64'(ldotop_lock),  64'(e.lock));
            chk("sat",   64'(ldotop_sat),   64'(e.sat));
        end
    end

    function automatic logic [N_PASS-1:0] rnd_pat();
        return N_PASS'($urandom());
    endfunction

    initial begin
        bit seq_dith[9];
        int target;
        int test_left;
        bit rst, tst, valid, cmp;

        // Reset and slew up into the upper rail.
        drive(1, 0, '0, 0, 0);
        for (int i = 0; i < 5; i++) drive(0, 0, rnd_pat(), 1, 1);

        // Coarse-to-fine, lock entry, unlock on a load step.
        drive(1, 0, '0, 0, 0);
        drive(0, 0, '0, 1, 1);
        drive(0, 0, '0, 1, 0);
        for (int i = 0; i < 3; i++) drive(0, 0, '0, 1, (i % 2) == 0);
        drive(0, 0, '0, 0, 0);
        for (int i = 0; i < 3; i++) drive(0, 0, '0, 1, 1);

        // Test override while cmp_valid toggles, then release.
        for (int i = 0; i < 4; i++) drive(0, 1, 32'hA5A5_0F0F, (i % 2) == 0, 1);
        drive(0, 0, 32'hA5A5_0F0F, 0, 0);
        drive(0, 0, '0, 1, 0);

        // Lock at hold code 10 and exercise the locked phase with gapped reversals.
        seq_dith = '{0, 0, 1, 1, 1, 0, 1, 0, 1};
        drive(1, 0, '0, 0, 0);
        for (int i = 0; i < 9; i++) drive(0, 0, '0, 1, seq_dith[i]);
        for (int i = 0; i < 8; i++) drive(0, 0, '0, (i % 3) != 2, (i % 2) == 0);

        // Reset wins over test and valid in the middle of lock.
        drive(0, 1, 32'hA5A5_0F0F, 1, 1);
        drive(1, 1, 32'hA5A5_0F0F, 1, 1);
        drive(0, 0, '0, 0, 0);

        // Randomised tracking of a moving target with noise, test bursts and rare resets.
        target    = INIT_CODE;
        test_left = 0;
        for (int k = 0; k < 3000; k++) begin
            if (k % 250 == 0) target = $urandom_range(0, N_PASS);
            rst = ($urandom_range(0, 999) < 4);
            if (test_left == 0 && $urandom_range(0, 99) < 2) test_left = $urandom_range(1, 6);
            tst = (test_left > 0);
            if (test_left > 0) test_left--;
            valid = ($urandom_range(0, 9) < 7);
            cmp   = (m_code < target);
            if ($urandom_range(0, 9) == 0) cmp = ~cmp;
            drive(rst, tst, rnd_pat(), valid, cmp);
        end

        repeat (3) @(negedge ldotop_clk);
        chk("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
